clause_variables_accumulator: RTL and testbench

Streaming, pipelined successor of the combinational variables detector. Accepts one clause per beat on a valid/ready handshake, produces that clause's integer and boolean variable-presence masks with population counts, and accumulates the union of masks across a multi-clause constraint set delimited by `in_last`. It sits between the clause memory reader and the unsatisfied-clause selector. The union output tells the selector which variables a whole constraint set touches.

---
 rtl/clause_pkg.sv | 25 ++
 rtl/clause_presence_mask.sv | 26 ++
 rtl/clause_variables_accumulator.sv | 132 +++++++++++++
 tb/tb_clause_variables_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_pkg.sv
// rtl/clause_pkg.sv - shared widths, state type and width helpers for the clause accumulator
package clause_pkg;

  localparam int DEF_INT_INDEX_WIDTH  = 1;
  localparam int DEF_BOOL_INDEX_WIDTH = 1;
  localparam int DEF_INT_COEFF_WIDTH  = 4;
  localparam int BOOL_COEFF_W         = 2;
  localparam int DEF_COUNT_WIDTH      = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  // number of variables carried by a clause for a given index width
  function automatic int n_vars(input int index_width);
    return 1 << index_width;
  endfunction

  // popcount width able to hold the value n_vars(index_width)
  function automatic int pop_width(input int index_width);
    return index_width + 1;
  endfunction

endpackage

// File: rtl/clause_presence_mask.sv
// rtl/clause_presence_mask.sv - per-variable nonzero mask and popcount of a packed coefficient vector
module clause_presence_mask
  import clause_pkg::*;
#(
  parameter int INDEX_WIDTH = 1,
  parameter int COEFF_WIDTH = 4
) (
  input  logic [(2**INDEX_WIDTH)*COEFF_WIDTH-1:0] coefficients,
  output logic [(2**INDEX_WIDTH)-1:0]             mask,
  output logic [INDEX_WIDTH:0]                    count
);

  localparam int N_VARS = n_vars(INDEX_WIDTH);
  localparam int CNT_W  = pop_width(INDEX_WIDTH);

  // a variable is present when any bit of its coefficient is set
  always_comb begin
    mask  = '0;
    count = '0;
    for (int i = 0; i < N_VARS; i++) begin
      mask[i] = |coefficients[i*COEFF_WIDTH +: COEFF_WIDTH];
      count   = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/clause_variables_accumulator.sv
// rtl/clause_variables_accumulator.sv - streaming per-clause variable masks with per-set union accumulation
module clause_variables_accumulator
  import clause_pkg::*;
#(
  parameter int INT_INDEX_WIDTH  = DEF_INT_INDEX_WIDTH,
  parameter int BOOL_INDEX_WIDTH = DEF_BOOL_INDEX_WIDTH,
  parameter int INT_COEFF_WIDTH  = DEF_INT_COEFF_WIDTH,
  parameter int BOOL_COEFF_WIDTH = BOOL_COEFF_W,
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           clear,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic                                           in_last,
  input  logic [(2**INT_INDEX_WIDTH)*INT_COEFF_WIDTH-1:0]   in_integer_coefficients,
  input  logic [(2**BOOL_INDEX_WIDTH)*BOOL_COEFF_WIDTH-1:0] in_boolean_coefficients,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           out_last,
  output logic [(2**INT_INDEX_WIDTH)-1:0]                out_integer_variables,
  output logic [(2**BOOL_INDEX_WIDTH)-1:0]               out_boolean_variables,
  output logic [INT_INDEX_WIDTH:0]                       out_integer_count,
  output logic [BOOL_INDEX_WIDTH:0]                      out_boolean_count,
  output logic [(2**INT_INDEX_WIDTH)-1:0]                out_union_integer,
  output logic [(2**BOOL_INDEX_WIDTH)-1:0]               out_union_boolean,
  output logic [COUNT_WIDTH-1:0]                         out_clause_count
);

  localparam int N_INT  = n_vars(INT_INDEX_WIDTH);
  localparam int N_BOOL = n_vars(BOOL_INDEX_WIDTH);

  acc_state_t                  state;
  logic [N_INT-1:0]            acc_int;
  logic [N_BOOL-1:0]           acc_bool;
  logic [COUNT_WIDTH-1:0]      cnt;

  logic [N_INT-1:0]            mask_int;
  logic [N_BOOL-1:0]           mask_bool;
  logic [INT_INDEX_WIDTH:0]    pop_int;
  logic [BOOL_INDEX_WIDTH:0]   pop_bool;
  logic [N_INT-1:0]            union_int;
  logic [N_BOOL-1:0]           union_bool;
  logic [COUNT_WIDTH-1:0]      cnt_base;
  logic [COUNT_WIDTH-1:0]      cnt_next;
  logic                        accept;

  clause_presence_mask #(
    .INDEX_WIDTH (INT_INDEX_WIDTH),
    .COEFF_WIDTH (INT_COEFF_WIDTH)
  ) u_int_mask (
    .coefficients (in_integer_coefficients),
    .mask         (mask_int),
    .count        (pop_int)
  );

  clause_presence_mask #(
    .INDEX_WIDTH (BOOL_INDEX_WIDTH),
    .COEFF_WIDTH (BOOL_COEFF_WIDTH)
  ) u_bool_mask (
    .coefficients (in_boolean_coefficients),
    .mask         (mask_bool),
    .count        (pop_bool)
  );

  // single output stage without skid buffer: accept only when the stage frees up this cycle
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // a set always starts from an empty accumulator, so IDLE contributes nothing
  always_comb begin
    union_int  = mask_int;
    union_bool = mask_bool;
    cnt_base   = '0;
    if (state == ST_ACCUM) begin
      union_int  = acc_int | mask_int;
      union_bool = acc_bool | mask_bool;
      cnt_base   = cnt;
    end
    cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + COUNT_WIDTH'(1);
  end

  // set FSM, accumulator, clause counter and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      acc_int               <= '0;
      acc_bool              <= '0;
      cnt                   <= '0;
      out_valid             <= 1'b0;
      out_last              <= 1'b0;
      out_integer_variables <= '0;
      out_boolean_variables <= '0;
      out_integer_count     <= '0;
      out_boolean_count     <= '0;
      out_union_integer     <= '0;
      out_union_boolean     <= '0;
      out_clause_count      <= '0;
    end else if (clear) begin
      state     <= ST_IDLE;
      acc_int   <= '0;
      acc_bool  <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid             <= 1'b1;
      out_last              <= in_last;
      out_integer_variables <= mask_int;
      out_boolean_variables <= mask_bool;
      out_integer_count     <= pop_int;
      out_boolean_count     <= pop_bool;
      out_union_integer     <= union_int;
      out_union_boolean     <= union_bool;
      out_clause_count      <= cnt_next;
      if (in_last) begin
        state    <= ST_IDLE;
        acc_int  <= '0;
        acc_bool <= '0;
        cnt      <= '0;
      end else begin
        state    <= ST_ACCUM;
        acc_int  <= union_int;
        acc_bool <= union_bool;
        cnt      <= cnt_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clause_variables_accumulator.sv
// tb/tb_clause_variables_accumulator.sv - scoreboard bench for the clause variables accumulator
module tb_clause_variables_accumulator;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, in_last, out_ready;
  logic [7:0] in_ic;
  logic [3:0] in_bc;

  logic       in_ready, out_valid, out_last;
  logic [1:0] out_iv, out_bv, out_icnt, out_bcnt, out_ui, out_ub;
  logic [7:0] out_cc;

  logic       s_in_ready, s_out_valid, s_out_last;
  logic [1:0] s_iv, s_bv, s_icnt, s_bcnt, s_ui, s_ub, s_cc;

  always #5 clk = ~clk;

  clause_variables_accumulator dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_integer_coefficients(in_ic), .in_boolean_coefficients(in_bc),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_integer_variables(out_iv), .out_boolean_variables(out_bv),
    .out_integer_count(out_icnt), .out_boolean_count(out_bcnt),
    .out_union_integer(out_ui), .out_union_boolean(out_ub), .out_clause_count(out_cc)
  );

  clause_variables_accumulator #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .in_integer_coefficients(in_ic), .in_boolean_coefficients(in_bc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_last(s_out_last),
    .out_integer_variables(s_iv), .out_boolean_variables(s_bv),
    .out_integer_count(s_icnt), .out_boolean_count(s_bcnt),
    .out_union_integer(s_ui), .out_union_boolean(s_ub), .out_clause_count(s_cc)
  );

  typedef struct {
    logic [7:0] ic;
    logic [3:0] bc;
    logic       last;
    logic [1:0] im, bm, icnt, bcnt;
  } vec_t;

  typedef struct {
    logic [1:0] im, bm, icnt, bcnt, ui, ub;
    logic [7:0] cc;
    logic [1:0] cc2;
    logic       last;
  } exp_t;

  vec_t tbl [7];
  exp_t q [$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  logic [1:0] m_ui, m_ub;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ui  = 2'b00;
    m_ub  = 2'b00;
    m_cnt = 0;
  endtask

  // drive one beat, push its expected result on the accepting edge
  task automatic send(input logic [7:0] ic, input logic [3:0] bc, input logic last,
                      input logic [1:0] im, input logic [1:0] bm,
                      input logic [1:0] icnt, input logic [1:0] bcnt);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_ic    = ic;
    in_bc    = bc;
    in_last  = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok     = 1'b1;
        e.im   = im;
        e.bm   = bm;
        e.icnt = icnt;
        e.bcnt = bcnt;
        e.ui   = m_ui | im;
        e.ub   = m_ub | bm;
        e.cc   = (m_cnt + 1 > 255) ? 8'd255 : 8'(m_cnt + 1);
        e.cc2  = (m_cnt + 1 > 3) ? 2'd3 : 2'(m_cnt + 1);
        e.last = last;
        q.push_back(e);
        n_pushed++;
        if (last) model_reset();
        else begin
          m_ui = e.ui;
          m_ub = e.ub;
          m_cnt++;
        end
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // compare every beat the downstream consumes against the scoreboard head
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got out_valid 1 expected no pending beat");
      end else begin
        mon_e = q.pop_front();
        n_popped++;
        chk("int_mask", 32'(out_iv), 32'(mon_e.im));
        chk("bool_mask", 32'(out_bv), 32'(mon_e.bm));
        chk("int_count", 32'(out_icnt), 32'(mon_e.icnt));
        chk("bool_count", 32'(out_bcnt), 32'(mon_e.bcnt));
        chk("union_int", 32'(out_ui), 32'(mon_e.ui));
        chk("union_bool", 32'(out_ub), 32'(mon_e.ub));
        chk("clause_count", 32'(out_cc), 32'(mon_e.cc));
        chk("out_last", 32'(out_last), 32'(mon_e.last));
        chk("sat_valid", 32'(s_out_valid), 32'd1);
        chk("sat_masks", {28'd0, s_iv, s_bv}, {28'd0, mon_e.im, mon_e.bm});
        chk("sat_counts", {28'd0, s_icnt, s_bcnt}, {28'd0, mon_e.icnt, mon_e.bcnt});
        chk("sat_unions", {28'd0, s_ui, s_ub}, {28'd0, mon_e.ui, mon_e.ub});
        chk("sat_clause_count", 32'(s_cc), 32'(mon_e.cc2));
        chk("sat_last", 32'(s_out_last), 32'(mon_e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h05, 4'b1111, 1'b1, 2'b01, 2'b11, 2'd1, 2'd2};
    tbl[1] = '{8'h05, 4'b0000, 1'b0, 2'b01, 2'b00, 2'd1, 2'd0};
    tbl[2] = '{8'h30, 4'b0100, 1'b1, 2'b10, 2'b10, 2'd1, 2'd1};
    tbl[3] = '{8'h00, 4'b0000, 1'b1, 2'b00, 2'b00, 2'd0, 2'd0};
    tbl[4] = '{8'h80, 4'b1000, 1'b0, 2'b10, 2'b10, 2'd1, 2'd1};
    tbl[5] = '{8'hF1, 4'b0011, 1'b0, 2'b11, 2'b01, 2'd2, 2'd1};
    tbl[6] = '{8'h01, 4'b0001, 1'b1, 2'b01, 2'b01, 2'd1, 2'd1};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_ic = 8'h00; in_bc = 4'h0; out_ready = 1'b1;
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_data", {16'd0, out_iv, out_bv, out_ui, out_ub, out_icnt, out_bcnt}, 32'd0);
    chk("reset_clause_count", 32'(out_cc), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {30'd0, in_ready, s_in_ready}, 32'b11);
    chk("post_reset_out_valid", {30'd0, out_valid, s_out_valid}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      send(tbl[i].ic, tbl[i].bc, tbl[i].last, tbl[i].im, tbl[i].bm, tbl[i].icnt, tbl[i].bcnt);
    repeat (3) @(posedge clk); #1;

    // backpressure: second beat must stall while the first sits unconsumed
    out_ready = 1'b0;
    send(8'h05, 4'b0000, 1'b0, 2'b01, 2'b00, 2'd1, 2'd0);
    fork
      send(8'h30, 4'b0100, 1'b1, 2'b10, 2'b10, 2'd1, 2'd1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", {24'd0, out_iv, out_ui, 2'b00, out_last, 1'b0},
              {24'd0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0});
          chk("stall_hold_count", 32'(out_cc), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // clear with a pending beat: beat is discarded and the set restarts
    out_ready = 1'b0;
    send(8'h05, 4'b0000, 1'b0, 2'b01, 2'b00, 2'd1, 2'd0);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    out_ready = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(8'h30, 4'b0000, 1'b1, 2'b10, 2'b00, 2'd1, 2'd0);
    repeat (3) @(posedge clk); #1;

    // five-beat set: the narrow counter saturates at 3
    send(8'h01, 4'b0000, 1'b0, 2'b01, 2'b00, 2'd1, 2'd0);
    send(8'h10, 4'b0000, 1'b0, 2'b10, 2'b00, 2'd1, 2'd0);
    send(8'h00, 4'b0001, 1'b0, 2'b00, 2'b01, 2'd0, 2'd1);
    send(8'h00, 4'b0000, 1'b0, 2'b00, 2'b00, 2'd0, 2'd0);
    send(8'h00, 4'b0100, 1'b1, 2'b00, 2'b10, 2'd0, 2'd1);
    repeat (3) @(posedge clk); #1;

    // asynchronous reset mid-set while an output beat is held
    out_ready = 1'b0;
    send(8'h05, 4'b1111, 1'b0, 2'b01, 2'b11, 2'd1, 2'd2);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", {30'd0, out_valid, s_out_valid}, 32'd0);
    chk("async_reset_data", {24'd0, out_ui, out_ub, out_iv, out_bv}, 32'd0);
    chk("async_reset_count", 32'(out_cc), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    q.delete();
    model_reset();
    send(8'h30, 4'b0000, 1'b1, 2'b10, 2'b00, 2'd1, 2'd0);
    repeat (4) @(posedge clk); #1;

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("beats_after_reset", 32'(out_valid), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
